// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: exception codes, store FSM states
// and the low-mask helper used to build stall vectors.
package pipe_ctrl_pkg;

    localparam int unsigned MaxStages = 32;

    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_RI   = 32'h0a;
    localparam logic [31:0] EXC_OV   = 32'h0c;
    localparam logic [31:0] EXC_TRAP = 32'h0d;
    localparam logic [31:0] EXC_ERET = 32'h0e;
    localparam logic [31:0] EXC_TLB  = 32'h0f;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCommit
    } store_state_e;

    // Stage k freezes itself and every stage upstream of it: bits [k:0].
    function automatic logic [MaxStages-1:0] low_mask(input int unsigned k);
        if (k >= MaxStages - 1) begin
            return '1;
        end
        return (MaxStages'(1) << (k + 1)) - MaxStages'(1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// Signal bundle between the pipeline (master) and the pipeline controller (slave).
interface pipe_ctrl_gen_if #(
    parameter int unsigned NSTAGE = 6,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) ();

    logic [NSTAGE-1:0] stallreq_i;
    logic              mem_we_i;
    logic [31:0]       excepttype_i;
    logic [ADDR_W-1:0] ebase_i;
    logic [ADDR_W-1:0] cp0_epc_i;
    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [ADDR_W-1:0] new_pc;
    logic              mem_we_o;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output stallreq_i, mem_we_i, excepttype_i, ebase_i, cp0_epc_i,
        input  stall, flush, new_pc, mem_we_o, stall_cycles
    );

    modport slave (
        input  stallreq_i, mem_we_i, excepttype_i, ebase_i, cp0_epc_i,
        output stall, flush, new_pc, mem_we_o, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_gen_store_seq.sv
// Store sequencer: holds a store in its stage for STORE_WAIT cycles, then commits it while
// releasing the store stage.
module pipe_ctrl_gen_store_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE      = 6,
    parameter int unsigned STORE_STAGE = 4,
    parameter int unsigned STORE_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    output logic [NSTAGE-1:0] mask,
    output logic              commit
);

    localparam int unsigned CntW = (STORE_WAIT > 1) ? $clog2(STORE_WAIT) : 1;

    store_state_e    state;
    logic [CntW-1:0] cnt;

    function automatic logic [NSTAGE-1:0] stage_mask(input int unsigned k);
        logic [MaxStages-1:0] m;
        m = low_mask(k);
        return m[NSTAGE-1:0];
    endfunction

    // cnt counts the WAIT cycles still to go; the IDLE accept cycle is the first wait cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= StIdle;
            cnt   <= '0;
        end else if (abort) begin
            state <= StIdle;
            cnt   <= '0;
        end else if (!hold) begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (STORE_WAIT == 1) begin
                            state <= StCommit;
                        end else begin
                            state <= StWait;
                            cnt   <= CntW'(STORE_WAIT - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt <= CntW'(1)) begin
                        state <= StCommit;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StCommit: state <= StIdle;
                default:  state <= StIdle;
            endcase
        end
    end

    always_comb begin
        mask = '0;
        unique case (state)
            StIdle:   mask = start ? stage_mask(STORE_STAGE) : '0;
            StWait:   mask = stage_mask(STORE_STAGE);
            StCommit: mask = stage_mask(STORE_STAGE - 1);
            default:  mask = '0;
        endcase
    end

    assign commit = (state == StCommit) && !hold;

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline controller: merges stall requests with the store sequencer, redirects the PC on
// exceptions/ERET with a flush, and counts stalled cycles.
module pipe_ctrl_gen
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE      = 6,
    parameter int unsigned STORE_STAGE = 4,
    parameter int unsigned STORE_WAIT  = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TLB_OFFSET  = 0,
    parameter int unsigned CNT_W       = 32
) (
    input logic           clk,
    input logic           rst,
    pipe_ctrl_gen_if.slave bus
);

    logic              exc;
    logic              hold;
    logic [NSTAGE-1:0] req_mask;
    logic [NSTAGE-1:0] fsm_mask;
    logic              commit;
    logic [CNT_W-1:0]  cnt;

    function automatic logic [NSTAGE-1:0] stage_mask(input int unsigned k);
        logic [MaxStages-1:0] m;
        m = low_mask(k);
        return m[NSTAGE-1:0];
    endfunction

    assign exc  = |bus.excepttype_i;
    assign hold = |bus.stallreq_i;

    pipe_ctrl_gen_store_seq #(
        .NSTAGE      (NSTAGE),
        .STORE_STAGE (STORE_STAGE),
        .STORE_WAIT  (STORE_WAIT)
    ) u_store_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (bus.mem_we_i),
        .hold   (hold),
        .abort  (exc),
        .mask   (fsm_mask),
        .commit (commit)
    );

    always_comb begin
        req_mask = '0;
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            if (bus.stallreq_i[k]) begin
                req_mask = req_mask | stage_mask(k);
            end
        end
    end

    // Exceptions and reset both override every other output.
    always_comb begin
        bus.stall    = '0;
        bus.flush    = 1'b0;
        bus.new_pc   = '0;
        bus.mem_we_o = 1'b0;
        if (rst) begin
            if (exc) begin
                bus.flush = 1'b1;
                case (bus.excepttype_i)
                    EXC_ERET: bus.new_pc = bus.cp0_epc_i;
                    EXC_TLB:  bus.new_pc = bus.ebase_i + ADDR_W'(TLB_OFFSET);
                    default:  bus.new_pc = bus.ebase_i;
                endcase
            end else begin
                bus.stall    = req_mask | fsm_mask;
                bus.mem_we_o = commit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((|bus.stall) && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cycles = rst ? cnt : '0;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen: vector table, corner-case sequences and a random
// run against a cycle-level reference model.
module tb_pipe_ctrl_gen;

    localparam int unsigned NS   = 6;
    localparam int unsigned SS   = 4;
    localparam int unsigned SW   = 2;
    localparam int unsigned TLB  = 32'h180;
    localparam int unsigned CW   = 4;
    localparam logic [31:0] EBASE = 32'h8000_0000;
    localparam logic [31:0] EPC   = 32'h8000_1234;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_ctrl_gen_if #(.NSTAGE(NS), .ADDR_W(32), .CNT_W(CW)) bus ();

    pipe_ctrl_gen #(
        .NSTAGE      (NS),
        .STORE_STAGE (SS),
        .STORE_WAIT  (SW),
        .ADDR_W      (32),
        .TLB_OFFSET  (TLB),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  req;
        logic        we;
        logic [31:0] exc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_we;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: store in flight and how many cycles it has occupied.
    bit   m_active;
    int   m_j;
    int   m_cnt;

    function automatic vec_t mk(logic r, logic [5:0] q, logic w, logic [31:0] x, logic [5:0] s,
                                logic f, logic [31:0] p, logic o, logic [3:0] c);
        vec_t v;
        v.rst = r; v.req = q; v.we = w; v.exc = x;
        v.e_stall = s; v.e_flush = f; v.e_pc = p; v.e_we = o; v.e_cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive at negedge, compare 1 ns later, leave inputs stable through the next posedge.
    task automatic cycle(input vec_t v, input logic [31:0] eb, input logic [31:0] ep,
                         input string tag);
        @(negedge clk);
        rst              = v.rst;
        bus.stallreq_i   = v.req;
        bus.mem_we_i     = v.we;
        bus.excepttype_i = v.exc;
        bus.ebase_i      = eb;
        bus.cp0_epc_i    = ep;
        #1;
        check({tag, " stall"},  32'(bus.stall),        32'(v.e_stall));
        check({tag, " flush"},  32'(bus.flush),        32'(v.e_flush));
        check({tag, " new_pc"}, bus.new_pc,            v.e_pc);
        check({tag, " we"},     32'(bus.mem_we_o),     32'(v.e_we));
        check({tag, " cnt"},    32'(bus.stall_cycles), 32'(v.e_cnt));
    endtask

    function automatic int lm(input int k);
        return (1 << (k + 1)) - 1;
    endfunction

    initial begin
        vec_t v;
        bus.stallreq_i = '0; bus.mem_we_i = 1'b0; bus.excepttype_i = '0;
        bus.ebase_i = EBASE; bus.cp0_epc_i = EPC;
        repeat (2) @(posedge clk);

        //           rst req        we exc    stall      fl pc     we cnt
        vecs.push_back(mk(0, 6'h3f, 1, 32'h0e, 6'b000000, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h08, 0, 32'h00, 6'b001111, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 1));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 1));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 2));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b001111, 0, 0,     1, 3));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 4));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 4));
        vecs.push_back(mk(1, 6'h04, 1, 32'h00, 6'b011111, 0, 0,     0, 5));
        vecs.push_back(mk(1, 6'h04, 1, 32'h00, 6'b011111, 0, 0,     0, 6));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 7));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b001111, 0, 0,     1, 8));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 9));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 10));
        vecs.push_back(mk(1, 6'h00, 1, 32'h0e, 6'b000000, 1, EPC,   0, 11));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 11));
        vecs.push_back(mk(1, 6'h00, 0, 32'h0f, 6'b000000, 1, 32'h8000_0180, 0, 11));
        vecs.push_back(mk(1, 6'h00, 0, 32'h05, 6'b000000, 1, EBASE, 0, 11));
        vecs.push_back(mk(1, 6'h01, 0, 32'h00, 6'b000001, 0, 0,     0, 11));
        vecs.push_back(mk(1, 6'h20, 0, 32'h00, 6'b111111, 0, 0,     0, 12));
        vecs.push_back(mk(1, 6'h12, 0, 32'h00, 6'b011111, 0, 0,     0, 13));
        vecs.push_back(mk(1, 6'h01, 1, 32'h00, 6'b011111, 0, 0,     0, 14));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 15));
        vecs.push_back(mk(1, 6'h01, 0, 32'h00, 6'b000001, 0, 0,     0, 15));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 15));
        vecs.push_back(mk(0, 6'h01, 0, 32'h00, 6'b000000, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 0));
        vecs.push_back(mk(0, 6'h00, 1, 32'h00, 6'b000000, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 32'h01, 6'b000000, 1, EBASE, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i], EBASE, EPC, $sformatf("vec%0d", i));
        end

        // Exception during WAIT aborts the store; no write afterwards.
        cycle(mk(0, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 0), EBASE, EPC, "abort_rst");
        cycle(mk(1, 6'h00, 1, 32'h00, 6'b011111, 0, 0,     0, 0), EBASE, EPC, "abort_idle");
        cycle(mk(1, 6'h00, 1, 32'h08, 6'b000000, 1, EBASE, 0, 1), EBASE, EPC, "abort_exc");
        cycle(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 1), EBASE, EPC, "abort_after");
        cycle(mk(1, 6'h00, 0, 32'h00, 6'b000000, 0, 0,     0, 1), EBASE, EPC, "abort_after2");

        // Saturation over 20 stalled cycles, then a one-edge reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.stallreq_i = 6'h02;
        end
        @(negedge clk);
        bus.stallreq_i = '0;
        #1;
        check("sat cnt", 32'(bus.stall_cycles), 32'd15);
        @(negedge clk);
        rst = 1'b0; bus.stallreq_i = 6'h3f; bus.mem_we_i = 1'b1; bus.excepttype_i = 32'h0f;
        #1;
        check("rst stall", 32'(bus.stall), 32'd0);
        check("rst flush", 32'(bus.flush), 32'd0);
        check("rst new_pc", bus.new_pc, 32'd0);
        check("rst we", 32'(bus.mem_we_o), 32'd0);
        check("rst cnt", 32'(bus.stall_cycles), 32'd0);
        @(negedge clk);
        rst = 1'b1; bus.stallreq_i = '0; bus.mem_we_i = 1'b0; bus.excepttype_i = '0;
        #1;
        check("post-rst cnt", 32'(bus.stall_cycles), 32'd0);

        // Random run; model starts from a reset cycle.
        m_active = 0; m_j = 0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            logic [5:0]  req;
            logic        we, r, e_we;
            logic [31:0] x, eb, ep, e_pc;
            logic [5:0]  e_stall;
            int          rm, fm, jj, sel;
            bit          cur;
            logic [31:0] codes [8];
            codes = '{32'h01, 32'h08, 32'h0a, 32'h0c, 32'h0d, 32'h0e, 32'h0f, 32'h05};
            @(negedge clk);
            r   = ($urandom_range(63) != 0);
            sel = $urandom_range(7);
            req = (sel == 0) ? 6'($urandom) : (sel == 1) ? 6'(1 << $urandom_range(5)) : 6'h00;
            we  = 1'($urandom_range(1));
            sel = $urandom_range(15);
            x   = (sel == 0) ? codes[$urandom_range(7)] : (sel == 1) ? $urandom : 32'h0;
            eb  = $urandom;
            ep  = $urandom;
            rst = r; bus.stallreq_i = req; bus.mem_we_i = we; bus.excepttype_i = x;
            bus.ebase_i = eb; bus.cp0_epc_i = ep;

            cur = m_active || we;
            jj  = m_active ? m_j : 0;
            fm  = cur ? ((jj < int'(SW)) ? lm(SS) : lm(SS - 1)) : 0;
            rm  = 0;
            for (int k = 0; k < 6; k++) if (req[k]) rm = rm | lm(k);
            e_stall = (!r || x != 0) ? 6'h00 : 6'(rm | fm);
            e_we    = r && x == 0 && cur && jj == int'(SW) && req == 0;
            e_pc    = (!r || x == 0) ? 32'h0 : (x == 32'h0e) ? ep :
                      (x == 32'h0f) ? eb + TLB : eb;
            #1;
            check($sformatf("rnd%0d stall", n),  32'(bus.stall),        32'(e_stall));
            check($sformatf("rnd%0d flush", n),  32'(bus.flush),        32'(r && x != 0));
            check($sformatf("rnd%0d new_pc", n), bus.new_pc,            e_pc);
            check($sformatf("rnd%0d we", n),     32'(bus.mem_we_o),     32'(e_we));
            check($sformatf("rnd%0d cnt", n),    32'(bus.stall_cycles), r ? 32'(m_cnt) : 32'd0);

            if (!r) begin
                m_active = 0; m_cnt = 0;
            end else begin
                if (e_stall != 0 && m_cnt < 15) m_cnt++;
                if (x != 0) m_active = 0;
                else if (req == 0 && cur) begin
                    if (jj == int'(SW)) m_active = 0;
                    else begin
                        m_active = 1; m_j = jj + 1;
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
# pipe_ctrl_gen

Parametrised pipeline controller for the MIPS core: merges per-stage stall requests into a stall vector, sequences multi-cycle stores to memory, and redirects the PC on exceptions or ERET with a pipeline flush. Successor to the fixed six-stage controller: stage count, store wait length and TLB vector offset are parameters, and a saturating stall-cycle counter is added for profiling. Sits beside the pipeline registers and drives their stall and flush inputs, the PC mux and the memory write enable.

## Interface
- NSTAGE, 6, pipeline stages; stall bit k freezes stage k (0 = PC).
- STORE_STAGE, 4, stage index that issues stores (1 ≤ STORE_STAGE < NSTAGE).
- STORE_WAIT, 2, cycles a store occupies memory before commit (≥1).
- ADDR_W, 32, PC and EPC width.
- TLB_OFFSET, 0, added to ebase for the TLB-miss vector.
- CNT_W, 32, stall-counter width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising clk edge).
- stallreq_i  in  NSTAGE  bit k: stage k requests a stall.
- mem_we_i  in  1  store present in STORE_STAGE.
- excepttype_i  in  32  exception code from the mem stage; 0 = none.
- ebase_i  in  ADDR_W  exception base.
- cp0_epc_i  in  ADDR_W  return address for ERET.
- stall  out  NSTAGE  stall vector.
- flush  out  1  flush all pipeline registers.
- new_pc  out  ADDR_W  redirect target, valid while flush=1.
- mem_we_o  out  1  memory write strobe.
- stall_cycles  out  CNT_W  count of cycles with stall≠0, saturating.

## Operation
- Store FSM states: IDLE, WAIT, COMMIT; 2-bit state plus wait counter.
- IDLE: mem_we_i=1 → WAIT with cnt=STORE_WAIT-1 (COMMIT directly if STORE_WAIT=1).
- WAIT: contributes mask bits [STORE_STAGE:0]; cnt decrements; cnt==0 → COMMIT.
- COMMIT: contributes mask bits [STORE_STAGE-1:0]; mem_we_o=1; → IDLE.
- Any stallreq_i bit set: FSM holds state and counter, mem_we_o=0.
- Stall mask for request bit k: bits [k:0]. stall = OR of all request masks and the FSM mask.
- Exception (excepttype_i≠0) overrides everything: flush=1, stall=0, mem_we_o=0; FSM → IDLE next edge, aborting any store.
- new_pc by code: 0x0e (ERET) → cp0_epc_i; 0x0f (TLB miss) → ebase_i+TLB_OFFSET (mod 2^ADDR_W); 0x01, 0x08, 0x0a, 0x0c, 0x0d and any other nonzero code → ebase_i. new_pc=0 when flush=0.
- stall_cycles increments on each edge where stall≠0; holds at all-ones.

## Timing
- stall, flush, new_pc, mem_we_o: combinational from the current inputs and registered state; zero-cycle latency.
- Reset (rst==0): state IDLE, cnt 0, stall_cycles 0. While rst==0, all outputs are forced to 0, including stall, flush, new_pc and mem_we_o.
- Reset mid-store: the store is dropped and no mem_we_o pulse occurs.
- A store without stalls holds stall≠0 for STORE_WAIT+1 cycles, with mem_we_o high in the last of them only.
- mem_we_i is sampled only in IDLE. Re-assertion in the cycle after COMMIT starts a new store, which covers back-to-back stores.
- Exception and COMMIT in the same cycle: no write, and the FSM goes to IDLE.
- The stall-counter update uses the stall value actually output, including the 0 forced during an exception.

## Structure
- Shared package (pipe_ctrl_pkg): exception-code constants (EXC_INT, EXC_SYS, EXC_RI, EXC_OV, EXC_TRAP, EXC_ERET, EXC_TLB), store-FSM state typedef, and a function that builds the low mask (k → bits [k:0]).
- One natural sub-module is store_seq, which holds the store FSM and wait counter. Its outputs are the mask contribution and the commit flag.

## Test plan
- Defaults: pulse stallreq_i=6'b001000 for 1 cycle → stall=6'b001111 that cycle, stall_cycles=1.
- STORE_WAIT=2, hold mem_we_i=1 for 3 cycles → stall sequence 011111, 011111, 001111; mem_we_o=1 only in the third cycle; FSM back in IDLE.
- During WAIT, assert stallreq_i[2] for 2 cycles → FSM frozen; mem_we_o stays 0 and asserts only after the request drops. stall equals the OR of 000111 and 011111.
- excepttype_i=0x0e, cp0_epc_i=0x80001234 during COMMIT → flush=1, new_pc=0x80001234, mem_we_o=0, stall=0; IDLE next cycle.
- TLB_OFFSET=0x180, ebase_i=0x80000000, excepttype_i=0x0f → new_pc=0x80000180. Code 0x05 → new_pc=0x80000000, flush=1.
- CNT_W=4, stall held for 20 cycles → stall_cycles saturates at 15. Then rst=0 for 1 edge → all outputs 0 and the counter is 0.
